// File: rtl/riscv_pc_alu_dmem_if.sv
// Data-memory bus between the core control and the execution slice.
interface riscv_pc_alu_dmem_if;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  // Control side drives the strobes, address and store data; it gets load data back.
  modport master (
    output write_enable, read_enable, address, write_data,
    input  read_data
  );

  // Memory side.
  modport slave (
    input  write_enable, read_enable, address, write_data,
    output read_data
  );
endinterface

// File: rtl/riscv_pc_alu_dmem.sv
// Execution-side datapath slice: program counter, combinational ALU with zero
// flag, and word-organized data memory with registered read.
module riscv_pc_alu_dmem #(
  parameter int MEM_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       finish_flag,
  input  logic                       branch,
  input  logic [31:0]                branch_offset,
  output logic [31:0]                pc_reg,
  input  logic [3:0]                 ALUctl,
  input  logic [31:0]                A,
  input  logic [31:0]                B,
  output logic [31:0]                ALUout,
  output logic                       zero,
  riscv_pc_alu_dmem_if.slave         dmem
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  logic [31:0] pc_d, pc_q;
  logic [31:0] rdata_d, rdata_q;
  logic [AW-1:0] idx;

  // Contents start at zero; reset never clears them.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  // Byte address to word index; low two bits and bits above the depth are dropped.
  assign idx = dmem.address[AW+1:2];

  // Next PC: finish freezes, branch adds a signed offset, else step one word.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (finish_flag)  pc_d = pc_q;
    else if (branch)  pc_d = pc_q + branch_offset;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_reg = pc_q;

  // ALU; unsupported codes yield zero so the zero flag reads 1.
  always_comb begin
    ALUout = '0;
    case (ALUctl)
      OP_AND: ALUout = A & B;
      OP_OR:  ALUout = A | B;
      OP_ADD: ALUout = A + B;
      OP_SUB: ALUout = A - B;
      OP_SLT: ALUout = {31'd0, $signed(A) < $signed(B)};
      OP_NOR: ALUout = ~(A | B);
      default: ALUout = '0;
    endcase
  end

  assign zero = (ALUout == 32'd0);

  // Load data: capture the old word on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (dmem.read_enable) rdata_d = mem[idx];
  end

  // Load register; reset clears it even mid-program.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  // Store port; deliberately outside reset so a store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (dmem.write_enable) mem[idx] <= dmem.write_data;
  end

  assign dmem.read_data = rdata_q;
endmodule

// File: tb/tb_riscv_pc_alu_dmem.sv
// Directed bench for riscv_pc_alu_dmem: PC sequencing, ALU codes, memory access.
module tb_riscv_pc_alu_dmem;
  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset, finish_flag, branch;
  logic [31:0] branch_offset, pc_reg, A, B, ALUout;
  logic [3:0]  ALUctl;
  logic        zero;
  int          errors = 0;
  int          checks = 0;

  riscv_pc_alu_dmem_if bus ();

  riscv_pc_alu_dmem #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .finish_flag(finish_flag), .branch(branch),
    .branch_offset(branch_offset), .pc_reg(pc_reg), .ALUctl(ALUctl),
    .A(A), .B(B), .ALUout(ALUout), .zero(zero), .dmem(bus.slave)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before inputs change or outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_out, input logic exp_zero, input string tag);
    ALUctl = op; A = a; B = b;
    #1;
    chk({tag, "_out"}, ALUout, exp_out);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  initial begin
    reset = 1'b1; finish_flag = 1'b0; branch = 1'b0; branch_offset = '0;
    ALUctl = '0; A = '0; B = '0;
    bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    bus.address = '0; bus.write_data = '0;
    #2;

    // Reset state
    step();
    chk("rst_pc", pc_reg, 32'd0);
    chk("rst_rd", bus.read_data, 32'd0);
    reset = 1'b0;

    // Free-running PC
    step(); chk("pc_4", pc_reg, 32'd4);
    step(); chk("pc_8", pc_reg, 32'd8);
    step(); chk("pc_12", pc_reg, 32'd12);

    // Finish freezes
    finish_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk("pc_freeze", pc_reg, 32'd12);
    end
    finish_flag = 1'b0;
    step(); chk("pc_16", pc_reg, 32'd16);

    // Backward branch then resume
    branch = 1'b1; branch_offset = 32'hFFFF_FFF8;
    step(); chk("pc_branch_back", pc_reg, 32'd8);
    branch = 1'b0;
    step(); chk("pc_after_branch", pc_reg, 32'd12);

    // Finish beats branch
    branch = 1'b1; finish_flag = 1'b1;
    step(); chk("pc_finish_over_branch", pc_reg, 32'd12);
    branch = 1'b0; finish_flag = 1'b0; branch_offset = '0;

    // ALU
    alu(4'd0,  32'd12, 32'd10, 32'd8,          1'b0, "and");
    alu(4'd1,  32'd12, 32'd10, 32'd14,         1'b0, "or");
    alu(4'd2,  32'd12, 32'd10, 32'd22,         1'b0, "add");
    alu(4'd6,  32'd12, 32'd10, 32'd2,          1'b0, "sub");
    alu(4'd12, 32'd12, 32'd10, 32'hFFFF_FFF1,  1'b0, "nor");
    alu(4'd6,  32'd5,  32'd5,  32'd0,          1'b1, "sub_eq");
    alu(4'd7,  32'hFFFF_FFFF, 32'd1, 32'd1,    1'b0, "slt_neg");
    alu(4'd7,  32'd1, 32'hFFFF_FFFF, 32'd0,    1'b1, "slt_pos");
    alu(4'd2,  32'hFFFF_FFFF, 32'd1, 32'd0,    1'b1, "add_wrap");
    alu(4'd3,  32'd12, 32'd10, 32'd0,          1'b1, "unsupported");

    // Store then load
    bus.write_enable = 1'b1; bus.address = 32'd8; bus.write_data = 32'hDEAD_BEEF;
    step();
    bus.write_enable = 1'b0; bus.read_enable = 1'b1;
    step(); chk("ld_8", bus.read_data, 32'hDEAD_BEEF);
    bus.address = 32'd9;
    step(); chk("ld_9_low_bits", bus.read_data, 32'hDEAD_BEEF);
    bus.address = 32'd8 + 32'(4 * MEM_WORDS);
    step(); chk("ld_wrap", bus.read_data, 32'hDEAD_BEEF);

    // Read-before-write on same index
    bus.read_enable = 1'b0; bus.write_enable = 1'b1;
    bus.address = 32'd4; bus.write_data = 32'h11;
    step();
    bus.read_enable = 1'b1; bus.write_data = 32'h55;
    step(); chk("rbw_old", bus.read_data, 32'h11);
    bus.write_enable = 1'b0;
    step(); chk("rbw_new", bus.read_data, 32'h55);

    // Hold with read_enable low
    bus.read_enable = 1'b0; bus.address = 32'd8;
    step(); chk("rd_hold", bus.read_data, 32'h55);

    // Mid-run reset; a store in the reset cycle still lands
    bus.write_enable = 1'b1; bus.address = 32'd12; bus.write_data = 32'h1234;
    step();
    bus.write_enable = 1'b0; bus.read_enable = 1'b1;
    step(); chk("ld_1234", bus.read_data, 32'h1234);
    reset = 1'b1; bus.read_enable = 1'b0;
    bus.write_enable = 1'b1; bus.address = 32'd16; bus.write_data = 32'hABCD;
    step();
    chk("midrst_rd", bus.read_data, 32'd0);
    chk("midrst_pc", pc_reg, 32'd0);
    reset = 1'b0; bus.write_enable = 1'b0;
    bus.read_enable = 1'b1; bus.address = 32'd12;
    step(); chk("ld_after_rst", bus.read_data, 32'h1234);
    chk("pc_after_rst", pc_reg, 32'd4);
    bus.address = 32'd16;
    step(); chk("ld_store_in_rst", bus.read_data, 32'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
